flame_ctrl: RTL and testbench
=============================

// Module: flame_ctrl
// PURPOSE
//  Explosion sequencer sitting directly upstream of the flame sprite renderer.
//  Accepts a bomb detonation request on a grid cell and runs a fuse countdown.
//  Then plays the grow/hold/shrink flame animation, paced by the video frame tick.
//  Drives the renderer's flame_centerX/Y and sprite_num; flame_active gates its output.
// PARAMETERS
//  ORIGIN_X        64  pixel X of grid cell (0,0) top-left corner
//  ORIGIN_Y        32  pixel Y of grid cell (0,0) top-left corner
//  GRID_W          15  number of cells per row; cellX >= GRID_W is invalid
//  GRID_H          13  number of cells per column; cellY >= GRID_H is invalid
//  FUSE_FRAMES     120 frame ticks between accepted detonate and first flame sprite
//  FRAMES_PER_SPR  4   frame ticks each animation sprite is held (>=1)
//  HOLD_FRAMES     16  frame ticks sprite 4 is held at full size (>=1)
// PORTS
//  clk            in   1   pixel clock
//  reset          in   1   synchronous, active-high reset
//  frame_tick     in   1   one-cycle pulse per video frame (start of vblank)
//  detonate       in   1   one-cycle request to start an explosion
//  bomb_cellX     in   4   grid column of the bomb, sampled when detonate=1
//  bomb_cellY     in   4   grid row of the bomb, sampled when detonate=1
//  busy           out  1   high from the cycle after acceptance until the return to IDLE
//  flame_active   out  1   high while a flame sprite is to be drawn
//  flame_centerX  out  10  sprite top-left X = ORIGIN_X + 32*cellX
//  flame_centerY  out  10  sprite top-left Y = ORIGIN_Y + 32*cellY
//  sprite_num     out  3   animation sprite index 0..4; 0 whenever flame_active=0
//  done           out  1   one-cycle pulse on the transition FADE->IDLE
// BEHAVIOUR
//  - Synchronous, active-high reset; all outputs are registered.
//  - Reset values: busy=0, flame_active=0, sprite_num=0, flame_centerX/Y=0, done=0.
//  - Reset has priority over every other input at any time and returns the FSM to IDLE.
//  - States: IDLE, ARMED, BURN, HOLD, FADE.
//  - IDLE: detonate=1 with cellX<GRID_W and cellY<GRID_H latches the centers (10-bit math).
//    -> ARMED and busy=1 on the next cycle; the tick counter clears to 0.
//  - IDLE: an out-of-range cell is dropped silently; the state stays IDLE.
//  - detonate while busy=1 is ignored; no queuing.
//  - Centers update only on acceptance and hold their value after IDLE is reached.
//  - ARMED: counts frame ticks; the FUSE_FRAMES-th tick -> BURN with sprite_num=0.
//    flame_active=1 from the cycle after that tick.
//  - BURN: every FRAMES_PER_SPR ticks sprite_num increments 0->1->2->3->4.
//    The tick that would make it 4 moves to HOLD instead (sprite 4 shown in HOLD).
//  - HOLD: sprite_num=4; after HOLD_FRAMES ticks -> FADE with sprite_num=3.
//  - FADE: every FRAMES_PER_SPR ticks sprite_num decrements 3->2->1->0.
//    The tick that ends sprite 0 moves to IDLE: flame_active=0, busy=0, done=1 for 1 cycle.
//  - A tick on the same cycle as acceptance is not counted; counting starts the next cycle.
//  - The tick counter is wide enough for max(FUSE_FRAMES,HOLD_FRAMES); it clears on each state change.
//  - Latency: flame_active rises (FUSE_FRAMES ticks + 1 cycle) after acceptance.
//  - Total flame time is (4+4)*FRAMES_PER_SPR + HOLD_FRAMES ticks.
// STRUCTURE
//  - flame_pkg holds the state typedef, SPRITE_SIZE=32, NUM_SPRITES=5,
//    and FLAME_TRANSPARENT=8'd137.
//  - One sub-module, tick_counter: counts frame_tick pulses; inputs clear and a terminal count;
//    output is a one-cycle expire pulse.
//  - FSM, center computation and output registers live in flame_ctrl.
// TESTING (bench params FUSE_FRAMES=3, FRAMES_PER_SPR=2, HOLD_FRAMES=2, ORIGIN 64/32)
//  - Reset mid-BURN at sprite 2 -> next cycle: all outputs 0, state IDLE.
//    A detonate on the following cycle is accepted normally.
//  - detonate cell(2,3) -> centers 128/128, busy=1 next cycle.
//    After 3 ticks flame_active=1, sprite_num=0.
//  - Full run after that: sprite sequence 0,0,1,1,2,2,3,3,4,4,3,3,2,2,1,1,0,0 per tick.
//    Then done=1 for 1 cycle; busy=0 and flame_active=0 on the same cycle.
//  - detonate cell(15,0) and cell(0,13) in IDLE -> busy stays 0, centers unchanged.
//  - Second detonate(5,5) during ARMED and during FADE -> ignored.
//    Centers stay 128/128 and the sequence length is unchanged.
//  - detonate and frame_tick on the same cycle -> that tick is not counted.
//    flame_active rises 1 cycle after the 3rd later tick.

Source files
------------

// File: rtl/flame_pkg.sv
// rtl/flame_pkg.sv - shared types and constants for the flame explosion sequencer
package flame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        BURN,
        HOLD,
        FADE
    } flame_state_t;

    localparam int SPRITE_SIZE = 32;
    localparam int NUM_SPRITES = 5;
    localparam logic [7:0] FLAME_TRANSPARENT = 8'd137;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - frame tick counter with synchronous clear and terminal-count expire pulse
module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clear,
    input  logic [W-1:0] terminal,
    output logic         expire
);

    logic [W-1:0] count;

    // Expire is combinational with the tick itself so the owner can change state on that edge.
    assign expire = tick && (count == terminal - W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/flame_ctrl.sv
// rtl/flame_ctrl.sv - bomb fuse countdown and grow/hold/shrink flame animation sequencer
module flame_ctrl
    import flame_pkg::*;
#(
    parameter int ORIGIN_X       = 64,
    parameter int ORIGIN_Y       = 32,
    parameter int GRID_W         = 15,
    parameter int GRID_H         = 13,
    parameter int FUSE_FRAMES    = 120,
    parameter int FRAMES_PER_SPR = 4,
    parameter int HOLD_FRAMES    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       detonate,
    input  logic [3:0] bomb_cellX,
    input  logic [3:0] bomb_cellY,
    output logic       busy,
    output logic       flame_active,
    output logic [9:0] flame_centerX,
    output logic [9:0] flame_centerY,
    output logic [2:0] sprite_num,
    output logic       done
);

    localparam int CNT_MAX = max2(FUSE_FRAMES, max2(FRAMES_PER_SPR, HOLD_FRAMES));
    localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [2:0] TOP_SPRITE = 3'(NUM_SPRITES - 1);

    flame_state_t state;
    logic [CW-1:0] terminal;
    logic          expire;
    logic          cnt_clear;
    logic          cell_ok;

    always_comb begin
        terminal = CW'(FRAMES_PER_SPR);
        case (state)
            ARMED:   terminal = CW'(FUSE_FRAMES);
            HOLD:    terminal = CW'(HOLD_FRAMES);
            default: terminal = CW'(FRAMES_PER_SPR);
        endcase
    end

    // Holding the counter clear in IDLE makes a tick on the acceptance cycle uncounted.
    assign cnt_clear = (state == IDLE) || expire;
    assign cell_ok   = ({1'b0, bomb_cellX} < 5'(GRID_W)) && ({1'b0, bomb_cellY} < 5'(GRID_H));

    tick_counter #(
        .W(CW)
    ) u_tick_counter (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick),
        .clear    (cnt_clear),
        .terminal (terminal),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            flame_active  <= 1'b0;
            flame_centerX <= '0;
            flame_centerY <= '0;
            sprite_num    <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (detonate && cell_ok) begin
                        flame_centerX <= 10'(ORIGIN_X) + 10'(SPRITE_SIZE) * {6'd0, bomb_cellX};
                        flame_centerY <= 10'(ORIGIN_Y) + 10'(SPRITE_SIZE) * {6'd0, bomb_cellY};
                        busy          <= 1'b1;
                        state         <= ARMED;
                    end
                end
                ARMED: begin
                    if (expire) begin
                        state        <= BURN;
                        flame_active <= 1'b1;
                        sprite_num   <= '0;
                    end
                end
                BURN: begin
                    if (expire) begin
                        if (sprite_num == TOP_SPRITE - 3'd1) begin
                            state      <= HOLD;
                            sprite_num <= TOP_SPRITE;
                        end else begin
                            sprite_num <= sprite_num + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (expire) begin
                        state      <= FADE;
                        sprite_num <= TOP_SPRITE - 3'd1;
                    end
                end
                FADE: begin
                    if (expire) begin
                        if (sprite_num == 3'd0) begin
                            state        <= IDLE;
                            flame_active <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            sprite_num <= sprite_num - 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flame_ctrl.sv
// tb/tb_flame_ctrl.sv - self-checking bench for flame_ctrl against a tick-count reference model
module tb_flame_ctrl;

    localparam int FUSE  = 3;
    localparam int FPS   = 2;
    localparam int HOLDF = 2;
    localparam int TOTAL = 8 * FPS + HOLDF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       detonate = 1'b0;
    logic [3:0] bomb_cellX = '0;
    logic [3:0] bomb_cellY = '0;
    logic       busy;
    logic       flame_active;
    logic [9:0] flame_centerX;
    logic [9:0] flame_centerY;
    logic [2:0] sprite_num;
    logic       done;

    always #5 clk = ~clk;

    flame_ctrl #(
        .ORIGIN_X       (64),
        .ORIGIN_Y       (32),
        .GRID_W         (15),
        .GRID_H         (13),
        .FUSE_FRAMES    (FUSE),
        .FRAMES_PER_SPR (FPS),
        .HOLD_FRAMES    (HOLDF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .detonate      (detonate),
        .bomb_cellX    (bomb_cellX),
        .bomb_cellY    (bomb_cellY),
        .busy          (busy),
        .flame_active  (flame_active),
        .flame_centerX (flame_centerX),
        .flame_centerY (flame_centerY),
        .sprite_num    (sprite_num),
        .done          (done)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    // Reference: an explosion is just "number of ticks seen since acceptance".
    bit m_busy = 0;
    int m_n = 0;
    int e_cx = 0, e_cy = 0, e_act = 0, e_spr = 0, e_done = 0;

    function automatic int spr_at(input int k);
        if (k < 4 * FPS) return k / FPS;
        if (k < 4 * FPS + HOLDF) return 4;
        return 3 - (k - 4 * FPS - HOLDF) / FPS;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_n = 0;
            e_cx = 0; e_cy = 0; e_done = 0;
        end else begin
            e_done = 0;
            if (!m_busy) begin
                if (detonate && bomb_cellX < 15 && bomb_cellY < 13) begin
                    m_busy = 1;
                    m_n = 0;
                    e_cx = 64 + 32 * int'(bomb_cellX);
                    e_cy = 32 + 32 * int'(bomb_cellY);
                end
            end else if (frame_tick) begin
                m_n++;
                if (m_n == FUSE + TOTAL) begin
                    m_busy = 0;
                    e_done = 1;
                end
            end
        end
        e_act = (m_busy && m_n >= FUSE) ? 1 : 0;
        e_spr = e_act ? spr_at(m_n - FUSE) : 0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("flame_active", 32'(flame_active), e_act);
            check("sprite_num", 32'(sprite_num), e_spr);
            check("flame_centerX", 32'(flame_centerX), e_cx);
            check("flame_centerY", 32'(flame_centerY), e_cy);
            check("done", 32'(done), e_done);
        end
    end

    task automatic cyc(input bit t, input bit d, input int x, input int y, input bit r);
        @(negedge clk);
        frame_tick = t;
        detonate   = d;
        bomb_cellX = 4'(x);
        bomb_cellY = 4'(y);
        reset      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i = 0;
        while (busy && i < 300) begin
            cyc(1, 0, 0, 0, 0);
            i++;
        end
        check("drain_timeout", 32'(busy), 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    int lit_seq [18] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk_en = 1;
        check("reset_busy", 32'(busy), 0);
        check("reset_centerX", 32'(flame_centerX), 0);

        // Directed full run on cell (2,3) with ignored re-detonates in ARMED and FADE.
        cyc(0, 1, 2, 3, 0);
        check("accept_busy", 32'(busy), 1);
        check("accept_centerX", 32'(flame_centerX), 128);
        check("accept_centerY", 32'(flame_centerY), 128);
        for (int i = 0; i < 3; i++) begin
            cyc(0, (i == 1), 5, 5, 0);
            check("fuse_inactive", 32'(flame_active), 0);
            cyc(1, 0, 0, 0, 0);
        end
        check("fuse_active", 32'(flame_active), 1);
        check("fuse_sprite", 32'(sprite_num), 0);
        for (int k = 0; k < 18; k++) begin
            cyc(0, (k == 14), 5, 5, 0);
            check("seq_sprite", 32'(sprite_num), 32'(lit_seq[k]));
            check("seq_active", 32'(flame_active), 1);
            cyc(1, 0, 0, 0, 0);
        end
        check("end_done", 32'(done), 1);
        check("end_busy", 32'(busy), 0);
        check("end_active", 32'(flame_active), 0);
        cyc(0, 0, 0, 0, 0);
        check("done_pulse", 32'(done), 0);
        check("hold_centerX", 32'(flame_centerX), 128);

        // Out-of-range cells are dropped.
        cyc(0, 1, 15, 0, 0);
        check("oor_x_busy", 32'(busy), 0);
        cyc(0, 1, 0, 13, 0);
        check("oor_y_busy", 32'(busy), 0);
        check("oor_centerY", 32'(flame_centerY), 128);

        // Tick on the acceptance cycle is not counted.
        cyc(1, 1, 0, 0, 0);
        check("same_busy", 32'(busy), 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("same_2nd", 32'(flame_active), 0);
        cyc(1, 0, 0, 0, 0);
        check("same_3rd", 32'(flame_active), 1);
        drain();

        // Reset mid-BURN at sprite 2, then immediate re-acceptance.
        cyc(0, 1, 2, 3, 0);
        for (int i = 0; i < 60 && sprite_num != 3'd2; i++) cyc(1, 0, 0, 0, 0);
        check("reach_spr2", 32'(sprite_num), 2);
        cyc(0, 0, 0, 0, 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_active", 32'(flame_active), 0);
        check("rst_sprite", 32'(sprite_num), 0);
        check("rst_center", 32'({flame_centerX, flame_centerY}), 0);
        cyc(0, 1, 1, 1, 0);
        check("re_busy", 32'(busy), 1);
        check("re_centerX", 32'(flame_centerX), 96);
        check("re_centerY", 32'(flame_centerY), 64);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                ($urandom_range(0, 599) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
